srm_controller: RTL

Instruction-level sequencer for the 16-bit datapath. It latches one instruction, decodes it, and steps a Moore FSM that drives every datapath control input: readnum/writenum, vsel, write, loada/b/c, loads, asel/bsel, shift, ALUop, plus sign-extended sximm5/sximm8. It sits between the instruction source and the datapath; the top-level cpu wrapper instantiates both and wires them port-to-port.

---
 rtl/srm_pkg.sv | 49 ++++
 rtl/srm_controller_if.sv | 35 +++
 rtl/srm_decoder.sv | 32 +++
 rtl/srm_controller.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/srm_pkg.sv
// Shared definitions for the srm instruction sequencer: state encoding,
// opcode/sub-op fields, writeback select codes, ALU op codes and the
// register-number selector used between the FSM and the decoder.
package srm_pkg;

  localparam logic [2:0] ST_WAIT      = 3'd0;
  localparam logic [2:0] ST_DECODE    = 3'd1;
  localparam logic [2:0] ST_WRITE_IMM = 3'd2;
  localparam logic [2:0] ST_GET_A     = 3'd3;
  localparam logic [2:0] ST_GET_B     = 3'd4;
  localparam logic [2:0] ST_ALU       = 3'd5;
  localparam logic [2:0] ST_WRITE_REG = 3'd6;

  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_ALU = 3'b101;

  localparam logic [1:0] SUB_MOV_REG = 2'b00;
  localparam logic [1:0] SUB_MOV_IMM = 2'b10;
  localparam logic [1:0] SUB_ADD     = 2'b00;
  localparam logic [1:0] SUB_CMP     = 2'b01;
  localparam logic [1:0] SUB_AND     = 2'b10;
  localparam logic [1:0] SUB_MVN     = 2'b11;

  localparam logic [1:0] VSEL_MDATA = 2'b00;
  localparam logic [1:0] VSEL_IMM8  = 2'b01;
  localparam logic [1:0] VSEL_PC    = 2'b10;
  localparam logic [1:0] VSEL_DP    = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  localparam logic [1:0] NSEL_RN = 2'd0;
  localparam logic [1:0] NSEL_RD = 2'd1;
  localparam logic [1:0] NSEL_RM = 2'd2;

  // MOV reg reuses the adder with A forced to zero, so it always adds.
  function automatic logic [1:0] alu_op_for(input logic [2:0] op, input logic [1:0] sub);
    if (op == OP_MOV) return ALU_ADD;
    case (sub)
      SUB_ADD: return ALU_ADD;
      SUB_CMP: return ALU_SUB;
      SUB_AND: return ALU_AND;
      default: return ALU_NOT;
    endcase
  endfunction

endpackage

// File: rtl/srm_controller_if.sv
// Instruction-source / datapath control bundle of the srm sequencer.
// master: instruction source + datapath side (drives in/load/s).
// slave : the sequencer (drives w and every datapath control).
interface srm_controller_if;
  logic [15:0] in;
  logic        load;
  logic        s;
  logic        w;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic [1:0]  vsel;
  logic        write;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [15:0] sximm8;
  logic [15:0] sximm5;

  modport master (
    output in, load, s,
    input  w, readnum, writenum, vsel, write, loada, loadb, loadc, loads,
           asel, bsel, shift, ALUop, sximm8, sximm5
  );

  modport slave (
    input  in, load, s,
    output w, readnum, writenum, vsel, write, loada, loadb, loadc, loads,
           asel, bsel, shift, ALUop, sximm8, sximm5
  );
endinterface

// File: rtl/srm_decoder.sv
// Combinational instruction decoder: splits the IR into fields, sign-extends
// the 5- and 8-bit immediates and picks Rn/Rd/Rm by nsel.
// Ports: ir (instruction register), nsel (register selector) ->
//        op, sub, sh, reg_num, sximm5, sximm8.
module srm_decoder
  import srm_pkg::*;
(
  input  logic [15:0] ir,
  input  logic [1:0]  nsel,
  output logic [2:0]  op,
  output logic [1:0]  sub,
  output logic [1:0]  sh,
  output logic [2:0]  reg_num,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8
);

  assign op     = ir[15:13];
  assign sub    = ir[12:11];
  assign sh     = ir[4:3];
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};

  always_comb begin
    case (nsel)
      NSEL_RD: reg_num = ir[7:5];
      NSEL_RM: reg_num = ir[2:0];
      default: reg_num = ir[10:8];
    endcase
  end

endmodule

// File: rtl/srm_controller.sv
// Instruction-level sequencer: latches an instruction while idle, then steps
// a Moore FSM that drives every datapath control for that instruction.
// Ports: clk, reset_n (async, active low), bus (slave side of
//        srm_controller_if: in/load/s in, w and datapath controls out).
//
// state        | meaning
// WAIT         | idle, w=1, IR may be loaded
// DECODE       | classify IR, pick first step
// WRITE_IMM    | write sximm8 into Rn
// GET_A        | load A from Rn
// GET_B        | load B from Rm
// ALU          | run ALU into C (or status for CMP)
// WRITE_REG    | write C into Rd
module srm_controller
  import srm_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  srm_controller_if.slave bus
);

  logic [2:0]  state, state_next;
  logic [15:0] ir;
  logic [2:0]  op, reg_num;
  logic [1:0]  sub, sh, nsel;
  logic [15:0] sximm5, sximm8;

  srm_decoder u_decoder (
    .ir      (ir),
    .nsel    (nsel),
    .op      (op),
    .sub     (sub),
    .sh      (sh),
    .reg_num (reg_num),
    .sximm5  (sximm5),
    .sximm8  (sximm8)
  );

  logic is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn;
  assign is_mov_imm = (op == OP_MOV) && (sub == SUB_MOV_IMM);
  assign is_mov_reg = (op == OP_MOV) && (sub == SUB_MOV_REG);
  assign is_alu     = (op == OP_ALU);
  assign is_cmp     = is_alu && (sub == SUB_CMP);
  assign is_mvn     = is_alu && (sub == SUB_MVN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_WAIT;
      ir    <= 16'h0000;
    end else begin
      state <= state_next;
      if (state == ST_WAIT && bus.load) ir <= bus.in;
    end
  end

  always_comb begin
    state_next = ST_WAIT;
    case (state)
      ST_WAIT:      state_next = bus.s ? ST_DECODE : ST_WAIT;
      ST_DECODE: begin
        if (is_mov_imm)              state_next = ST_WRITE_IMM;
        else if (is_mov_reg || is_mvn) state_next = ST_GET_B;
        else if (is_alu)             state_next = ST_GET_A;
        else                         state_next = ST_WAIT;
      end
      ST_WRITE_IMM: state_next = ST_WAIT;
      ST_GET_A:     state_next = ST_GET_B;
      ST_GET_B:     state_next = ST_ALU;
      ST_ALU:       state_next = is_cmp ? ST_WAIT : ST_WRITE_REG;
      ST_WRITE_REG: state_next = ST_WAIT;
      default:      state_next = ST_WAIT;
    endcase
  end

  always_comb begin
    case (state)
      ST_GET_B:     nsel = NSEL_RM;
      ST_WRITE_REG: nsel = NSEL_RD;
      default:      nsel = NSEL_RN;
    endcase
  end

  logic       w, write, loada, loadb, loadc, loads, asel;
  logic [2:0] readnum, writenum;
  logic [1:0] vsel, shift, alu_op;

  always_comb begin
    w        = 1'b0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    vsel     = VSEL_MDATA;
    shift    = 2'b00;
    alu_op   = ALU_ADD;
    case (state)
      ST_WAIT: w = 1'b1;
      ST_WRITE_IMM: begin
        write    = 1'b1;
        vsel     = VSEL_IMM8;
        writenum = reg_num;
      end
      ST_GET_A: begin
        loada   = 1'b1;
        readnum = reg_num;
      end
      ST_GET_B: begin
        loadb   = 1'b1;
        readnum = reg_num;
      end
      ST_ALU: begin
        shift  = sh;
        alu_op = alu_op_for(op, sub);
        asel   = is_mov_reg || is_mvn;
        loadc  = !is_cmp;
        loads  = is_cmp;
      end
      ST_WRITE_REG: begin
        write    = 1'b1;
        vsel     = VSEL_DP;
        writenum = reg_num;
      end
      default: ;
    endcase
  end

  assign bus.w        = w;
  assign bus.write    = write;
  assign bus.loada    = loada;
  assign bus.loadb    = loadb;
  assign bus.loadc    = loadc;
  assign bus.loads    = loads;
  assign bus.asel     = asel;
  // Reserved for a future immediate-operand ALU form.
  assign bus.bsel     = 1'b0;
  assign bus.readnum  = readnum;
  assign bus.writenum = writenum;
  assign bus.vsel     = vsel;
  assign bus.shift    = shift;
  assign bus.ALUop    = alu_op;
  assign bus.sximm8   = sximm8;
  assign bus.sximm5   = sximm5;

endmodule
